// File: rtl/javk_bus_arb_if.sv
// Signal bundle for the JAVK two-master memory bus arbiter.
// The "slave" modport is the arbiter's view (it serves both masters and
// drives the memory pins); the "master" modport is the environment's view
// (the two requesters plus the external memory/databus).
interface javk_bus_arb_if;
  logic        m0_req;
  logic        m1_req;
  logic        m0_rw;
  logic        m1_rw;
  logic [15:0] m0_addr;
  logic [15:0] m1_addr;
  logic [7:0]  m0_wdata;
  logic [7:0]  m1_wdata;
  logic        m0_gnt;
  logic        m1_gnt;
  logic        m0_ack;
  logic        m1_ack;
  logic [7:0]  m0_rdata;
  logic [7:0]  m1_rdata;
  logic [15:0] addrbus;
  logic        rw;
  logic [7:0]  mem_wdata;
  logic        mem_oe;
  logic [7:0]  mem_rdata;

  modport slave (
    input  m0_req, m1_req, m0_rw, m1_rw, m0_addr, m1_addr, m0_wdata, m1_wdata,
    input  mem_rdata,
    output m0_gnt, m1_gnt, m0_ack, m1_ack, m0_rdata, m1_rdata,
    output addrbus, rw, mem_wdata, mem_oe
  );

  modport master (
    output m0_req, m1_req, m0_rw, m1_rw, m0_addr, m1_addr, m0_wdata, m1_wdata,
    output mem_rdata,
    input  m0_gnt, m1_gnt, m0_ack, m1_ack, m0_rdata, m1_rdata,
    input  addrbus, rw, mem_wdata, mem_oe
  );
endinterface

// File: rtl/javk_bus_arb.sv
// Two-master round-robin arbiter/sequencer for the JAVK 16-bit address,
// 8-bit data memory bus. Each transaction goes IDLE/DONE -> ACCESS
// (WAIT_STATES+1 cycles) -> DONE (one ack cycle). All outputs are decoded
// from registered state, so there is no path from req to any output.
module javk_bus_arb #(
  parameter int WAIT_STATES = 1
) (
  input  logic          clk,
  input  logic          rst,
  javk_bus_arb_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  localparam logic [3:0] WS_LAST = 4'(WAIT_STATES);

  state_t      state_q, state_d;
  logic [3:0]  wcnt_q, wcnt_d;
  logic        last_q, last_d;     // also the current owner once granted
  logic        cap_rw_q, cap_rw_d;
  logic [15:0] cap_addr_q, cap_addr_d;
  logic [7:0]  cap_wdata_q, cap_wdata_d;

  logic [1:0]  req;
  logic        any_req;
  logic        winner;
  logic        read_done;

  assign req     = {bus.m1_req, bus.m0_req};
  assign any_req = |req;
  // On a tie the master that was not served last wins; otherwise the sole requester.
  assign winner  = (&req) ? ~last_q : req[1];

  // Read data is sampled on the edge that closes the final ACCESS cycle.
  assign read_done = (state_q == ACCESS) && (wcnt_q == WS_LAST) && cap_rw_q;

  // State and captured-transaction registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      wcnt_q      <= 4'd0;
      last_q      <= 1'b1;
      cap_rw_q    <= 1'b1;
      cap_addr_q  <= 16'h0000;
      cap_wdata_q <= 8'h00;
    end else begin
      state_q     <= state_d;
      wcnt_q      <= wcnt_d;
      last_q      <= last_d;
      cap_rw_q    <= cap_rw_d;
      cap_addr_q  <= cap_addr_d;
      cap_wdata_q <= cap_wdata_d;
    end
  end

  // Next-state logic: arbitrate in IDLE and DONE, count wait states in ACCESS.
  always_comb begin
    state_d     = state_q;
    wcnt_d      = wcnt_q;
    last_d      = last_q;
    cap_rw_d    = cap_rw_q;
    cap_addr_d  = cap_addr_q;
    cap_wdata_d = cap_wdata_q;
    case (state_q)
      IDLE, DONE: begin
        if (any_req) begin
          state_d     = ACCESS;
          last_d      = winner;
          wcnt_d      = 4'd0;
          cap_rw_d    = winner ? bus.m1_rw    : bus.m0_rw;
          cap_addr_d  = winner ? bus.m1_addr  : bus.m0_addr;
          cap_wdata_d = winner ? bus.m1_wdata : bus.m0_wdata;
        end else begin
          state_d = IDLE;
        end
      end
      ACCESS: begin
        wcnt_d = wcnt_q + 4'd1;
        if (wcnt_q == WS_LAST) begin
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Per-master read data holding registers; each keeps its value until
  // that master's next read completes.
  for (genvar gi = 0; gi < 2; gi++) begin : g_rdata
    logic [7:0] rdata_q;
    // Latch memory data for the owning master at the end of a read access.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        rdata_q <= 8'h00;
      end else if (read_done && (last_q == 1'(gi))) begin
        rdata_q <= bus.mem_rdata;
      end
    end
  end

  assign bus.m0_rdata = g_rdata[0].rdata_q;
  assign bus.m1_rdata = g_rdata[1].rdata_q;

  // Grant covers ACCESS and DONE of the owner; ack is the DONE cycle only.
  assign bus.m0_gnt = (state_q != IDLE) && !last_q;
  assign bus.m1_gnt = (state_q != IDLE) &&  last_q;
  assign bus.m0_ack = (state_q == DONE) && !last_q;
  assign bus.m1_ack = (state_q == DONE) &&  last_q;

  // Memory pins carry the captured transaction only during ACCESS.
  always_comb begin
    bus.addrbus   = 16'h0000;
    bus.rw        = 1'b1;
    bus.mem_wdata = 8'h00;
    bus.mem_oe    = 1'b0;
    if (state_q == ACCESS) begin
      bus.addrbus   = cap_addr_q;
      bus.rw        = cap_rw_q;
      bus.mem_wdata = cap_wdata_q;
      bus.mem_oe    = ~cap_rw_q;
    end
  end

endmodule

// File: tb/tb_javk_bus_arb.sv
// Directed bench for javk_bus_arb: one DUT with WAIT_STATES=1 and one with
// WAIT_STATES=0. Inputs change and outputs are sampled at the falling edge.
module tb_javk_bus_arb;
  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  javk_bus_arb_if bus1();
  javk_bus_arb_if bus0();

  javk_bus_arb #(.WAIT_STATES(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
  javk_bus_arb #(.WAIT_STATES(0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));

  task automatic clear_inputs();
    bus1.m0_req = 0; bus1.m1_req = 0; bus1.m0_rw = 1; bus1.m1_rw = 1;
    bus1.m0_addr = 0; bus1.m1_addr = 0; bus1.m0_wdata = 0; bus1.m1_wdata = 0;
    bus1.mem_rdata = 0;
    bus0.m0_req = 0; bus0.m1_req = 0; bus0.m0_rw = 1; bus0.m1_rw = 1;
    bus0.m0_addr = 0; bus0.m1_addr = 0; bus0.m0_wdata = 0; bus0.m1_wdata = 0;
    bus0.mem_rdata = 0;
  endtask

  task automatic test_reset();
    int acks;
    rst = 1'b1;
    @(negedge clk); @(negedge clk);
    n_cmp++; if ({bus1.m0_gnt, bus1.m1_gnt, bus1.m0_ack, bus1.m1_ack, bus1.mem_oe} !== 5'b0) begin n_bad++; $display("FAIL reset_ctl: got %b want 00000", {bus1.m0_gnt, bus1.m1_gnt, bus1.m0_ack, bus1.m1_ack, bus1.mem_oe}); end
    n_cmp++; if ({bus1.addrbus, bus1.rw, bus1.mem_wdata} !== {16'h0000, 1'b1, 8'h00}) begin n_bad++; $display("FAIL reset_bus: got %h/%b/%h want 0000/1/00", bus1.addrbus, bus1.rw, bus1.mem_wdata); end
    n_cmp++; if ({bus1.m0_rdata, bus1.m1_rdata} !== 16'h0000) begin n_bad++; $display("FAIL reset_rdata: got %h want 0000", {bus1.m0_rdata, bus1.m1_rdata}); end
    rst = 1'b0;
    bus1.m0_req = 1; bus1.m0_rw = 0; bus1.m0_addr = 16'h1234; bus1.m0_wdata = 8'h77;
    @(negedge clk);
    n_cmp++; if ({bus1.addrbus, bus1.mem_oe, bus1.m0_gnt} !== {16'h1234, 1'b1, 1'b1}) begin n_bad++; $display("FAIL reset_pre_access: got %h/%b/%b want 1234/1/1", bus1.addrbus, bus1.mem_oe, bus1.m0_gnt); end
    #2 rst = 1'b1;
    #1;
    n_cmp++; if ({bus1.addrbus, bus1.rw, bus1.mem_oe, bus1.mem_wdata, bus1.m0_gnt} !== {16'h0000, 1'b1, 1'b0, 8'h00, 1'b0}) begin n_bad++; $display("FAIL reset_async: got %h/%b/%b/%h/%b want 0000/1/0/00/0", bus1.addrbus, bus1.rw, bus1.mem_oe, bus1.mem_wdata, bus1.m0_gnt); end
    bus1.m0_req = 0;
    @(negedge clk);
    rst = 1'b0;
    acks = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (bus1.m0_ack || bus1.m0_gnt) acks++;
    end
    n_cmp++; if (acks !== 0) begin n_bad++; $display("FAIL reset_no_ack: got %0d cycles with ack/gnt want 0", acks); end
  endtask

  task automatic test_single_read();
    bus1.m0_req = 1; bus1.m0_rw = 1; bus1.m0_addr = 16'h8000; bus1.mem_rdata = 8'h00;
    @(negedge clk);
    n_cmp++; if ({bus1.m0_gnt, bus1.m0_ack, bus1.addrbus} !== {1'b1, 1'b0, 16'h8000}) begin n_bad++; $display("FAIL read_c1: got %b/%b/%h want 1/0/8000", bus1.m0_gnt, bus1.m0_ack, bus1.addrbus); end
    bus1.m0_addr = 16'h0000;
    @(negedge clk);
    n_cmp++; if ({bus1.m0_ack, bus1.addrbus, bus1.rw, bus1.mem_oe} !== {1'b0, 16'h8000, 1'b1, 1'b0}) begin n_bad++; $display("FAIL read_c2: got %b/%h/%b/%b want 0/8000/1/0", bus1.m0_ack, bus1.addrbus, bus1.rw, bus1.mem_oe); end
    bus1.mem_rdata = 8'hA5;
    @(negedge clk);
    n_cmp++; if ({bus1.m0_ack, bus1.m0_gnt, bus1.addrbus} !== {1'b1, 1'b1, 16'h0000}) begin n_bad++; $display("FAIL read_ack: got %b/%b/%h want 1/1/0000", bus1.m0_ack, bus1.m0_gnt, bus1.addrbus); end
    n_cmp++; if (bus1.m0_rdata !== 8'hA5) begin n_bad++; $display("FAIL read_data: got %h want a5", bus1.m0_rdata); end
    bus1.m0_req = 0; bus1.mem_rdata = 8'hFF;
    @(negedge clk);
    n_cmp++; if ({bus1.m0_ack, bus1.m0_gnt, bus1.m0_rdata} !== {1'b0, 1'b0, 8'hA5}) begin n_bad++; $display("FAIL read_after: got %b/%b/%h want 0/0/a5", bus1.m0_ack, bus1.m0_gnt, bus1.m0_rdata); end
  endtask

  task automatic test_single_write();
    int m0_gnts = 0;
    int m1_acks = 0;
    bus1.m1_req = 1; bus1.m1_rw = 0; bus1.m1_addr = 16'hFFFF; bus1.m1_wdata = 8'h3C;
    for (int t = 1; t <= 5; t++) begin
      @(negedge clk);
      if (bus1.m0_gnt) m0_gnts++;
      if (bus1.m1_ack) m1_acks++;
      if (t <= 2) begin
        n_cmp++; if ({bus1.rw, bus1.mem_oe, bus1.mem_wdata, bus1.addrbus, bus1.m1_gnt} !== {1'b0, 1'b1, 8'h3C, 16'hFFFF, 1'b1}) begin n_bad++; $display("FAIL write_c%0d: got %b/%b/%h/%h/%b want 0/1/3c/ffff/1", t, bus1.rw, bus1.mem_oe, bus1.mem_wdata, bus1.addrbus, bus1.m1_gnt); end
        bus1.m1_addr = 16'h0000; bus1.m1_wdata = 8'h00; bus1.m1_rw = 1;
      end
      if (t == 3) begin
        n_cmp++; if ({bus1.m1_ack, bus1.mem_oe, bus1.rw, bus1.m0_rdata} !== {1'b1, 1'b0, 1'b1, 8'hA5}) begin n_bad++; $display("FAIL write_ack: got %b/%b/%b/%h want 1/0/1/a5", bus1.m1_ack, bus1.mem_oe, bus1.rw, bus1.m0_rdata); end
        bus1.m1_req = 0;
      end
    end
    n_cmp++; if ({m0_gnts, m1_acks} !== {32'd0, 32'd1}) begin n_bad++; $display("FAIL write_counts: got m0_gnt=%0d m1_ack=%0d want 0/1", m0_gnts, m1_acks); end
  endtask

  task automatic test_fairness();
    logic [1:0] exp_gnt;
    logic [1:0] exp_ack;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bus1.m0_req = 1; bus1.m0_rw = 1; bus1.m0_addr = 16'h1000;
    bus1.m1_req = 1; bus1.m1_rw = 1; bus1.m1_addr = 16'h2000;
    for (int t = 1; t <= 13; t++) begin
      @(negedge clk);
      if (t <= 12) begin
        exp_gnt = (((t - 1) / 3) % 2 == 1) ? 2'b10 : 2'b01;
        exp_ack = (t % 3 == 0) ? exp_gnt : 2'b00;
      end else begin
        exp_gnt = 2'b00;
        exp_ack = 2'b00;
      end
      n_cmp++; if ({bus1.m1_gnt, bus1.m0_gnt, bus1.m1_ack, bus1.m0_ack} !== {exp_gnt, exp_ack}) begin n_bad++; $display("FAIL fair_c%0d: got gnt=%b ack=%b want gnt=%b ack=%b", t, {bus1.m1_gnt, bus1.m0_gnt}, {bus1.m1_ack, bus1.m0_ack}, exp_gnt, exp_ack); end
      if (t == 12) begin
        bus1.m0_req = 0; bus1.m1_req = 0;
      end
    end
  endtask

  task automatic test_zero_wait();
    logic [7:0]  exp_rd;
    logic [15:0] exp_addr;
    bus0.m0_req = 1; bus0.m0_rw = 1; bus0.m0_addr = 16'h0A00; bus0.mem_rdata = 8'h10;
    for (int t = 1; t <= 7; t++) begin
      @(negedge clk);
      if (t == 7) begin
        n_cmp++; if ({bus0.m0_gnt, bus0.m0_ack} !== 2'b00) begin n_bad++; $display("FAIL zw_idle: got %b want 00", {bus0.m0_gnt, bus0.m0_ack}); end
      end else if (t % 2 == 1) begin
        exp_addr = 16'h0A00 + 16'((t - 1) / 2);
        n_cmp++; if ({bus0.m0_ack, bus0.addrbus} !== {1'b0, exp_addr}) begin n_bad++; $display("FAIL zw_access_c%0d: got %b/%h want 0/%h", t, bus0.m0_ack, bus0.addrbus, exp_addr); end
        bus0.mem_rdata = 8'h10 + 8'(t);
      end else begin
        exp_rd = 8'h10 + 8'(t - 1);
        n_cmp++; if ({bus0.m0_ack, bus0.m0_rdata} !== {1'b1, exp_rd}) begin n_bad++; $display("FAIL zw_ack_c%0d: got %b/%h want 1/%h", t, bus0.m0_ack, bus0.m0_rdata, exp_rd); end
        bus0.m0_addr = 16'h0A00 + 16'(t / 2);
        if (t == 6) bus0.m0_req = 0;
      end
    end
  endtask

  task automatic test_dropped();
    int bad = 0;
    int acks = 0;
    @(negedge clk);
    bus1.m0_req = 1; bus1.m0_rw = 1; bus1.m0_addr = 16'h5555;
    #2 bus1.m0_req = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (bus1.m0_gnt || bus1.m0_ack) bad++;
    end
    n_cmp++; if (bad !== 0) begin n_bad++; $display("FAIL drop_before_grant: got %0d cycles with gnt/ack want 0", bad); end
    bus1.m1_req = 1; bus1.m1_rw = 1; bus1.m1_addr = 16'h4444;
    @(negedge clk);
    n_cmp++; if (bus1.m1_gnt !== 1'b1) begin n_bad++; $display("FAIL drop_grant: got %b want 1", bus1.m1_gnt); end
    bus1.m1_req = 0;
    for (int t = 2; t <= 6; t++) begin
      @(negedge clk);
      if (bus1.m1_ack) acks++;
      if (t == 3) begin
        n_cmp++; if (bus1.m1_ack !== 1'b1) begin n_bad++; $display("FAIL drop_ack_time: got %b want 1", bus1.m1_ack); end
      end
    end
    n_cmp++; if (acks !== 1) begin n_bad++; $display("FAIL drop_ack_count: got %0d want 1", acks); end
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_single_read();
    test_single_write();
    test_fairness();
    test_zero_wait();
    test_dropped();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/javk_bus_arb.md
# javk_bus_arb

Two-master arbiter and sequencer for the JAVK 16-bit-address / 8-bit-data memory bus. It shares one memory port between master 0 (the CPU core) and master 1 (DMA or debug loader). It runs a per-transaction request/grant/acknowledge handshake with round-robin fairness and a configurable number of memory wait states. It sits between the masters and the top-level bus pads; tri-state resolution of the data bus is done outside, using `mem_oe`.

## Interface
- `WAIT_STATES`, default 1: extra memory cycles per access; legal range 0–15.
- `clk` in 1: system clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `m0_req` / `m1_req` in 1: request a transaction; level-sensitive.
- `m0_rw` / `m1_rw` in 1: 1 = read, 0 = write (same polarity as the bus `rw`).
- `m0_addr` / `m1_addr` in 16: transaction address.
- `m0_wdata` / `m1_wdata` in 8: write data.
- `m0_gnt` / `m1_gnt` out 1: master owns the bus; one-hot or zero.
- `m0_ack` / `m1_ack` out 1: one-cycle completion pulse.
- `m0_rdata` / `m1_rdata` out 8: read data; valid while ack is high and held until that master's next read.
- `addrbus` out 16: memory address.
- `rw` out 1: memory direction; 1 = read.
- `mem_wdata` out 8: data for the external databus driver.
- `mem_oe` out 1: enables the external data driver; equals `~rw` during a write access, otherwise 0.
- `mem_rdata` in 8: databus value as seen by the arbiter.

## Operation
- States: IDLE, ACCESS, DONE. A 4-bit wait counter `wcnt` and a `last` register (index of the last master served).
- **IDLE**
  - Bus outputs idle: `addrbus` = 0, `rw` = 1, `mem_oe` = 0, `mem_wdata` = 0. Both gnt low, both ack low.
  - On an edge with any req high, pick the winner:
    - If only one master requests, it wins.
    - If both request, the master ≠ `last` wins.
  - At that edge: capture the winner's rw/addr/wdata into internal registers, set `last` = winner, `wcnt` = 0, set the winner's gnt, and go to ACCESS.
- **ACCESS**
  - Lasts `WAIT_STATES`+1 cycles.
  - `addrbus`, `rw` and `mem_wdata` come from the captured registers; `mem_oe` = ~captured rw. The winner's gnt stays high.
  - `wcnt` increments each edge.
  - On the edge where `wcnt` == `WAIT_STATES`:
    - If it is a read, latch `mem_rdata` into that master's rdata register.
    - Go to DONE.
- **DONE** (exactly one cycle)
  - Winner's ack = 1; gnt stays high. Bus outputs return to idle values.
  - Arbitration is performed exactly as in IDLE, with the updated `last`. If any req is high, go to ACCESS (back-to-back, no IDLE cycle); otherwise go to IDLE.
- Requester rules:
  - Hold req high until ack.
  - A req still high during the ack cycle is a new request.
  - addr/rw/wdata must be valid on the granting edge; after that they are don't-care.
- Boundary conditions:
  - req dropped before the granting edge: no transaction, no ack.
  - req dropped during ACCESS: the transaction still completes and ack still pulses.
  - Both masters requesting continuously: strict alternation, one transaction each.
  - A single master requesting continuously: back-to-back transactions.
  - `WAIT_STATES` = 0: ACCESS lasts 1 cycle.
  - `addr` = 0xFFFF: passed through unchanged; no address arithmetic is performed.
- Reset mid-transaction: the transaction is abandoned with no ack; the memory may have seen a partial write.

## Timing
- Reset values: state = IDLE, `last` = 1 (master 0 wins the first tie), `wcnt` = 0, gnt = 0, ack = 0, rdata = 0, `addrbus` = 0, `rw` = 1, `mem_oe` = 0, `mem_wdata` = 0.
- All outputs are registered or decoded from registered state only; there is no combinational path from req to any output.
- Latency: with req sampled at edge E, gnt is high from E. Memory address is valid for cycles E+1 … E+`WAIT_STATES`+1. Ack is high in cycle E+`WAIT_STATES`+2.
- Throughput: one transaction per `WAIT_STATES`+2 cycles under continuous demand.
- Read data: sampled at the end of the last ACCESS cycle, i.e. `WAIT_STATES`+1 cycles after the address is presented.

## Test plan
- **Reset values:** assert `rst` asynchronously mid-ACCESS (m0 write, addr 0x1234) → all outputs reach reset values immediately; no ack follows; `addrbus` = 0, `rw` = 1.
- **Single read:** `WAIT_STATES` = 1, m0 reads 0x8000 with memory returning 0xA5 → `addrbus` = 0x8000 for 2 cycles; `m0_ack` pulses 3 cycles after the granting edge; `m0_rdata` = 0xA5.
- **Single write:** m1 writes 0x3C to 0xFFFF → `rw` = 0, `mem_oe` = 1, `mem_wdata` = 0x3C for 2 cycles; `m1_ack` pulses once; m0 never granted.
- **Fairness:** both reqs held high for 4 transactions from reset → grant order m0, m1, m0, m1; no IDLE cycles between them.
- **Zero wait and back-to-back:** `WAIT_STATES` = 0, m0 holds req for 3 reads → acks every 2 cycles.
- **Dropped request:** req dropped before grant → no gnt, no ack; req dropped during ACCESS → ack still pulses once.
